// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared constants and types for the register scoreboard.
//   NREG   : number of architectural registers
//   IDX_W  : register index width
//   slot_st_t : issue-slot state encoding (ST_EMPTY / ST_FULL)
package reg_scoreboard_pkg;
   localparam int NREG  = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_st_t;
endpackage

// File: rtl/reg_pend_counter.sv
// reg_pend_counter
//   Pending-write counter for one architectural register.
//   Ports:
//     clk, rst      : clock, async active-low reset
//     inc           : a new writer of this register issued
//     dec_a, dec_b  : writeback acks (EX, MA) for this register
//     cnt           : outstanding writes
//     err           : sticky, set when the net update would go below zero
module reg_pend_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec_a,
   input  logic             dec_b,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);

   // Two extra bits: one for the +1 headroom, one for the sign.
   logic signed [CNT_W+1:0] net;
   logic                    under;

   always_comb begin
      net = $signed({2'b00, cnt})
          + $signed({{(CNT_W+1){1'b0}}, inc})
          - $signed({{(CNT_W+1){1'b0}}, dec_a})
          - $signed({{(CNT_W+1){1'b0}}, dec_b});
      under = net[CNT_W+1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (under) begin
         cnt <= '0;
         err <= 1'b1;
      end else begin
         cnt <= net[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Hazard controller between decode and EX/MA. Tracks outstanding writes
//   per register, keeps a shadow of the latest written values, forwards
//   same-cycle writebacks, and holds one registered issue slot toward EX.
//   Ports:
//     clk, rst                         : clock, async active-low reset
//     issue_valid/issue_ready          : decoder handshake
//     rs1/rs2_idx, rs1/rs2_used        : source operands
//     rd_idx, wb_e                     : destination and write enable
//     out_valid/out_ready              : issue slot handshake toward EX
//     out_rs1_val, out_rs2_val, out_rd : slot contents
//     ex_/ma_ack, _idx, _val           : writeback-done pulses
//     stall_cycles                     : saturating stall counter
//     err_underflow                    : sticky ack-without-pending flag
//
//   Slot FSM
//   state    | meaning
//   ST_EMPTY | no operands held for EX
//   ST_FULL  | operands held, out_valid asserted until EX takes them
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int REG_SZ = 32,
   parameter int NREG   = 32,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [IDX_W-1:0]  rs1_idx,
   input  logic [IDX_W-1:0]  rs2_idx,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic              wb_e,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_SZ-1:0] out_rs1_val,
   output logic [REG_SZ-1:0] out_rs2_val,
   output logic [IDX_W-1:0]  out_rd,
   input  logic              ex_ack,
   input  logic              ma_ack,
   input  logic [IDX_W-1:0]  ex_idx,
   input  logic [IDX_W-1:0]  ma_idx,
   input  logic [REG_SZ-1:0] ex_val,
   input  logic [REG_SZ-1:0] ma_val,
   output logic [31:0]       stall_cycles,
   output logic              err_underflow
);

   logic [CNT_W-1:0]  pend_cnt [NREG];
   logic [NREG-1:0]   cnt_err;
   logic [REG_SZ-1:0] shadow   [NREG];

   slot_st_t state_q, state_d;
   logic     fire;
   logic     slot_free;

   // x0 has no counter: it is never pending and never flags underflow.
   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      if (r == 0) begin : g_x0
         assign pend_cnt[r] = '0;
         assign cnt_err[r]  = 1'b0;
      end else begin : g_reg
         reg_pend_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (fire && wb_e && (rd_idx == IDX_W'(r))),
            .dec_a (ex_ack && (ex_idx == IDX_W'(r))),
            .dec_b (ma_ack && (ma_idx == IDX_W'(r))),
            .cnt   (pend_cnt[r]),
            .err   (cnt_err[r])
         );
      end
   end

   assign err_underflow = |cnt_err;

   // Source resolution and forwarding. A same-cycle ack only resolves the
   // last outstanding write; with two in flight the ack may be the older one.
   logic              ex_hit1, ma_hit1, ex_hit2, ma_hit2;
   logic              rs1_ok, rs2_ok, rd_ok;
   logic [REG_SZ-1:0] rs1_fwd, rs2_fwd;

   always_comb begin
      ex_hit1 = ex_ack && (ex_idx == rs1_idx);
      ma_hit1 = ma_ack && (ma_idx == rs1_idx);
      ex_hit2 = ex_ack && (ex_idx == rs2_idx);
      ma_hit2 = ma_ack && (ma_idx == rs2_idx);

      rs1_ok = !rs1_used || (rs1_idx == '0) || (pend_cnt[rs1_idx] == '0) ||
               ((pend_cnt[rs1_idx] == CNT_W'(1)) && (ex_hit1 || ma_hit1));
      rs2_ok = !rs2_used || (rs2_idx == '0) || (pend_cnt[rs2_idx] == '0) ||
               ((pend_cnt[rs2_idx] == CNT_W'(1)) && (ex_hit2 || ma_hit2));
      rd_ok  = !wb_e || (rd_idx == '0) || (pend_cnt[rd_idx] != {CNT_W{1'b1}});

      // EX holds the younger producer, so it wins over MA.
      if (rs1_idx == '0)  rs1_fwd = '0;
      else if (ex_hit1)   rs1_fwd = ex_val;
      else if (ma_hit1)   rs1_fwd = ma_val;
      else                rs1_fwd = shadow[rs1_idx];

      if (rs2_idx == '0)  rs2_fwd = '0;
      else if (ex_hit2)   rs2_fwd = ex_val;
      else if (ma_hit2)   rs2_fwd = ma_val;
      else                rs2_fwd = shadow[rs2_idx];
   end

   assign issue_ready = rs1_ok && rs2_ok && rd_ok && slot_free;
   assign fire        = issue_valid && issue_ready;

   // Slot FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   // Slot FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (fire)                state_d = ST_FULL;
         ST_FULL:  if (out_ready && !fire)  state_d = ST_EMPTY;
         default:                           state_d = ST_EMPTY;
      endcase
   end

   // Slot FSM: outputs
   always_comb begin
      out_valid = (state_q == ST_FULL);
      slot_free = !out_valid || out_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_rs1_val <= '0;
         out_rs2_val <= '0;
         out_rd      <= '0;
      end else if (fire) begin
         out_rs1_val <= rs1_fwd;
         out_rs2_val <= rs2_fwd;
         out_rd      <= rd_idx;
      end
   end

   // MA first, then EX, so EX lands last when both target one register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      end else begin
         if (ma_ack && (ma_idx != '0)) shadow[ma_idx] <= ma_val;
         if (ex_ack && (ex_idx != '0)) shadow[ex_idx] <= ex_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (issue_valid && !issue_ready && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Directed, table-driven bench for reg_scoreboard plus hand sequences for
//   back-pressure, underflow, EX/MA forwarding priority and async reset.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [4:0]  rs1_idx = '0, rs2_idx = '0, rd_idx = '0;
   logic        rs1_used = 1'b0, rs2_used = 1'b0, wb_e = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rs1_val, out_rs2_val;
   logic [4:0]  out_rd;
   logic        ex_ack = 1'b0, ma_ack = 1'b0;
   logic [4:0]  ex_idx = '0, ma_idx = '0;
   logic [31:0] ex_val = '0, ma_val = '0;
   logic [31:0] stall_cycles;
   logic        err_underflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_scoreboard #(.REG_SZ(32), .NREG(32), .CNT_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .rs1_idx       (rs1_idx),
      .rs2_idx       (rs2_idx),
      .rs1_used      (rs1_used),
      .rs2_used      (rs2_used),
      .rd_idx        (rd_idx),
      .wb_e          (wb_e),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rs1_val   (out_rs1_val),
      .out_rs2_val   (out_rs2_val),
      .out_rd        (out_rd),
      .ex_ack        (ex_ack),
      .ma_ack        (ma_ack),
      .ex_idx        (ex_idx),
      .ma_idx        (ma_idx),
      .ex_val        (ex_val),
      .ma_val        (ma_val),
      .stall_cycles  (stall_cycles),
      .err_underflow (err_underflow)
   );

   typedef struct {
      logic        iv;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        wb;
      logic        exa;
      logic [4:0]  exi;
      logic [31:0] exv;
      logic        maa;
      logic [4:0]  mai;
      logic [31:0] mav;
      logic        exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_v1;
      logic [31:0] exp_v2;
      logic [4:0]  exp_rd;
   } vec_t;

   vec_t vec[$];

   function automatic vec_t mk(input int iv, input int rs1, input int u1,
                               input int rs2, input int u2, input int rd,
                               input int wb, input int exa, input int exi,
                               input logic [31:0] exv, input int maa,
                               input int mai, input logic [31:0] mav,
                               input int rdy, input int ov,
                               input logic [31:0] v1, input logic [31:0] v2,
                               input int erd);
      vec_t v;
      v.iv = iv[0];   v.rs1 = rs1[4:0]; v.u1 = u1[0];
      v.rs2 = rs2[4:0]; v.u2 = u2[0]; v.rd = rd[4:0]; v.wb = wb[0];
      v.exa = exa[0]; v.exi = exi[4:0]; v.exv = exv;
      v.maa = maa[0]; v.mai = mai[4:0]; v.mav = mav;
      v.exp_rdy = rdy[0]; v.exp_ov = ov[0];
      v.exp_v1 = v1; v.exp_v2 = v2; v.exp_rd = erd[4:0];
      return v;
   endfunction

   task automatic drive(input vec_t v);
      issue_valid = v.iv;
      rs1_idx = v.rs1;  rs1_used = v.u1;
      rs2_idx = v.rs2;  rs2_used = v.u2;
      rd_idx  = v.rd;   wb_e     = v.wb;
      ex_ack  = v.exa;  ex_idx   = v.exi; ex_val = v.exv;
      ma_ack  = v.maa;  ma_idx   = v.mai; ma_val = v.mav;
      out_ready = 1'b1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Checks the slot contents one edge after a row was applied.
   task automatic step(input string nm, input vec_t v);
      drive(v);
      @(negedge clk);
      chk({nm, " ready"}, 32'(issue_ready), 32'(v.exp_rdy));
      @(posedge clk); #1;
      chk({nm, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
      if (v.exp_ov) begin
         chk({nm, " rs1_val"}, out_rs1_val, v.exp_v1);
         chk({nm, " rs2_val"}, out_rs2_val, v.exp_v2);
         chk({nm, " rd"}, 32'(out_rd), 32'(v.exp_rd));
      end
   endtask

   initial begin
      //        iv rs1 u1 rs2 u2 rd wb exa exi exv      maa mai mav    rdy ov v1       v2       rd
      vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,     1, 0, 0,       0,       0));
      vec.push_back(mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 0,       0, 0, 0,     1, 1, 0,       0,       5));
      vec.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,       0, 0, 0,     0, 0, 0,       0,       0));
      vec.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,       0, 0, 0,     0, 0, 0,       0,       0));
      vec.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 5, 'h1234,  0, 0, 0,     1, 1, 'h1234,  0,       6));
      vec.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,       0, 0, 0,     1, 1, 0,       0,       7));
      vec.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,       0, 0, 0,     1, 1, 0,       0,       7));
      vec.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0,       1, 7, 10,    0, 0, 0,       0,       0));
      vec.push_back(mk(1, 7, 1, 5, 1, 8, 1, 1, 7, 20,      0, 0, 0,     1, 1, 20,      'h1234,  8));
      vec.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,       0, 0, 0,     1, 1, 0,       0,       3));
      vec.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,       0, 0, 0,     1, 1, 0,       0,       3));
      vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 'hAA,    1, 3, 'hBB,  1, 0, 0,       0,       0));
      vec.push_back(mk(1, 3, 1, 3, 1, 0, 1, 0, 0, 0,       0, 0, 0,     1, 1, 'hAA,    'hAA,    0));
      vec.push_back(mk(1, 0, 1, 6, 1, 0, 0, 0, 0, 0,       0, 0, 0,     0, 0, 0,       0,       0));
      vec.push_back(mk(1, 0, 1, 6, 1, 0, 0, 1, 0, 'h77,    1, 6, 'h66,  1, 1, 0,       'h66,    0));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,      0, 0, 0,     1, 1, 0,       0,       10));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,      0, 0, 0,     1, 1, 0,       0,       10));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,      0, 0, 0,     1, 1, 0,       0,       10));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,      0, 0, 0,     0, 0, 0,       0,       0));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 10, 1,     0, 0, 0,     0, 0, 0,       0,       0));
      vec.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,      0, 0, 0,     1, 1, 0,       0,       10));

      // Reset state
      #12;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst rs1_val", out_rs1_val, 32'd0);
      chk("rst rd", 32'(out_rd), 32'd0);
      chk("rst stall", stall_cycles, 32'd0);
      chk("rst err", 32'(err_underflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vec.size(); i++)
         step($sformatf("row%0d", i), vec[i]);

      chk("table stall", stall_cycles, 32'd6);
      chk("table err", 32'(err_underflow), 32'd0);

      // Back-pressure: slot full and EX not ready blocks issue
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp ready", 32'(issue_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold rd", 32'(out_rd), 32'd10);
      chk("bp stall", stall_cycles, 32'd7);
      // Drain and refill in the same cycle: no bubble
      step("bp reload", mk(1, 5, 1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h1234, 0, 11));
      chk("bp stall after", stall_cycles, 32'd7);

      // Underflow on x9, sticky, value still written
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h99, 1, 0, 0, 0, 0));
      @(posedge clk); #1;
      chk("uf err", 32'(err_underflow), 32'd1);
      step("uf read x9", mk(1, 9, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 1, 1, 'h99, 0, 12));
      chk("uf sticky", 32'(err_underflow), 32'd1);
      // EX beats MA on a same-cycle forward
      step("fwd ex>ma", mk(1, 12, 1, 0, 0, 0, 0, 1, 12, 'hE, 1, 12, 'hA, 1, 1, 'hE, 0, 0));
      step("shadow ex>ma", mk(1, 12, 1, 5, 1, 13, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hE, 'h1234, 13));

      // Async reset mid-stall with a full slot
      drive(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre-rst ready", 32'(issue_ready), 32'd0);
      @(posedge clk); #1;
      chk("pre-rst valid", 32'(out_valid), 32'd1);
      chk("pre-rst stall", stall_cycles, 32'd8);
      #2;
      rst = 1'b0;
      #1;
      chk("arst out_valid", 32'(out_valid), 32'd0);
      chk("arst rs1_val", out_rs1_val, 32'd0);
      chk("arst rs2_val", out_rs2_val, 32'd0);
      chk("arst rd", 32'(out_rd), 32'd0);
      chk("arst stall", stall_cycles, 32'd0);
      chk("arst err", 32'(err_underflow), 32'd0);
      chk("arst ready", 32'(issue_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      step("post-rst x9", mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      chk("post-rst stall", stall_cycles, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
